// File: rtl/traffic_phase_scheduler.sv
// Phase scheduler for the smart traffic light: picks main / side / left / pedestrian
// phases, offers them on a valid/ready handshake, waits for completion, then runs
// an all-red clearance before the next arbitration.
// Ports: clk/reset (sync, active-high); L/H queue thermometer codes; ped_btn request;
//        phase_ready/phase_done from light controller; phase_valid/phase_id/green_len
//        offer; busy (OFFER/RUN/CLEAR); ped_pending latched pedestrian request.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int PER_CAR   = 4,
  parameter int MAX_GREEN = 20,
  parameter int PED_GREEN = 8,
  parameter int ALLRED    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] L,
  input  logic [2:0] H,
  input  logic       ped_btn,
  input  logic       phase_ready,
  input  logic       phase_done,
  output logic       phase_valid,
  output logic [1:0] phase_id,
  output logic [4:0] green_len,
  output logic       busy,
  output logic       ped_pending
);

  typedef enum logic [1:0] {ARB, OFFER, RUN, CLEAR} state_t;

  // Round-robin slots for the non-main phases.
  localparam logic [1:0] SLOT_SIDE = 2'd0;
  localparam logic [1:0] SLOT_LEFT = 2'd1;
  localparam logic [1:0] SLOT_PED  = 2'd2;

  state_t     state;
  logic [1:0] rr;
  logic       main_due;
  logic [7:0] clr_cnt;

  logic [1:0] l_cnt, h_cnt;
  logic [2:0] req;
  logic [2:0] rot_req;
  logic [1:0] offset;
  logic [1:0] grantee;
  logic       ped_hs;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Modulo-3 add on slot indices.
  function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Computed at 8 bits so a large PER_CAR saturates at MAX_GREEN instead of wrapping.
  function automatic logic [4:0] car_green(input logic [1:0] cnt);
    logic [7:0] raw;
    raw = 8'(MIN_GREEN) + 8'(PER_CAR) * {6'd0, cnt};
    if (raw > 8'(MAX_GREEN)) raw = 8'(MAX_GREEN);
    return raw[4:0];
  endfunction

  assign l_cnt = popcnt3(L);
  assign h_cnt = popcnt3(H);
  assign req   = {ped_pending, (h_cnt != 2'd0), (l_cnt != 2'd0)};

  // Rotate the request vector so bit 0 is the slot the rr pointer names; the
  // first set bit then gives the distance from the pointer to the grantee.
  always_comb begin
    rot_req = req;
    case (rr)
      2'd1:    rot_req = {req[0], req[2], req[1]};
      2'd2:    rot_req = {req[1], req[0], req[2]};
      default: rot_req = req;
    endcase
    offset = 2'd2;
    if (rot_req[0])      offset = 2'd0;
    else if (rot_req[1]) offset = 2'd1;
    grantee = add3((rr == 2'd3) ? 2'd0 : rr, offset);
  end

  assign ped_hs = (state == OFFER) && phase_ready && (phase_id == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB;
      rr          <= SLOT_SIDE;
      main_due    <= 1'b0;
      clr_cnt     <= 8'd0;
      phase_valid <= 1'b0;
      phase_id    <= 2'd0;
      green_len   <= 5'd0;
      busy        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      // A press on the pedestrian handshake cycle re-arms the request.
      ped_pending <= ped_btn | (ped_pending & ~ped_hs);

      case (state)
        ARB: begin
          if (main_due || (req == 3'b000)) begin
            phase_id  <= 2'd0;
            green_len <= 5'(MIN_GREEN);
            main_due  <= 1'b0;
          end else begin
            phase_id <= grantee + 2'd1;
            if (grantee == SLOT_PED)
              green_len <= 5'(PED_GREEN);
            else if (grantee == SLOT_LEFT)
              green_len <= car_green(h_cnt);
            else
              green_len <= car_green(l_cnt);
            rr       <= add3(grantee, 2'd1);
            main_due <= 1'b1;
          end
          phase_valid <= 1'b1;
          busy        <= 1'b1;
          state       <= OFFER;
        end

        OFFER: begin
          if (phase_ready) begin
            phase_valid <= 1'b0;
            state       <= RUN;
          end
        end

        RUN: begin
          if (phase_done) begin
            if (ALLRED == 0) begin
              busy  <= 1'b0;
              state <= ARB;
            end else begin
              clr_cnt <= 8'd0;
              state   <= CLEAR;
            end
          end
        end

        CLEAR: begin
          if (clr_cnt == 8'(ALLRED - 1)) begin
            busy  <= 1'b0;
            state <= ARB;
          end else begin
            clr_cnt <= clr_cnt + 8'd1;
          end
        end

        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: directed phases followed by randomized
// queues / pedestrian presses, checked against a phase-level reference model.
// A second instance with PER_CAR=6 shares all inputs to check green clamping.
module tb_traffic_phase_scheduler;

  localparam int ALLRED = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] L, H;
  logic       ped_btn, phase_ready, phase_done;
  logic       phase_valid, busy, ped_pending;
  logic [1:0] phase_id;
  logic [4:0] green_len;
  logic       phase_valid2, busy2, ped_pending2;
  logic [1:0] phase_id2;
  logic [4:0] green_len2;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: phase-level view of the arbitration rules.
  bit m_main_due;
  int m_rr;        // 0 side, 1 left, 2 ped
  bit m_pend;

  traffic_phase_scheduler dut (
    .clk(clk), .reset(reset), .L(L), .H(H), .ped_btn(ped_btn),
    .phase_ready(phase_ready), .phase_done(phase_done),
    .phase_valid(phase_valid), .phase_id(phase_id), .green_len(green_len),
    .busy(busy), .ped_pending(ped_pending)
  );

  traffic_phase_scheduler #(.PER_CAR(6)) dut6 (
    .clk(clk), .reset(reset), .L(L), .H(H), .ped_btn(ped_btn),
    .phase_ready(phase_ready), .phase_done(phase_done),
    .phase_valid(phase_valid2), .phase_id(phase_id2), .green_len(green_len2),
    .busy(busy2), .ped_pending(ped_pending2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int car_len(input int per_car, input int cars);
    int v;
    v = 5 + per_car * cars;
    return (v > 20) ? 20 : v;
  endfunction

  // Decide the next grant from the current queues and pending request.
  task automatic predict(output int eid, output int elen, output int elen6);
    int  lc, hc, p;
    bit  found;
    lc = $countones(L);
    hc = $countones(H);
    eid = 0; elen = 5; elen6 = 5;
    if (m_main_due || (lc == 0 && hc == 0 && !m_pend)) begin
      m_main_due = 0;
    end else begin
      found = 0;
      for (int k = 0; k < 3; k++) begin
        p = (m_rr + k) % 3;
        if (!found && ((p == 0 && lc > 0) || (p == 1 && hc > 0) || (p == 2 && m_pend))) begin
          found = 1;
          eid   = p + 1;
          m_rr  = (p + 1) % 3;
        end
      end
      m_main_due = 1;
      if (eid == 3)      begin elen = 8; elen6 = 8; end
      else if (eid == 2) begin elen = car_len(4, hc); elen6 = car_len(6, hc); end
      else               begin elen = car_len(4, lc); elen6 = car_len(6, lc); end
    end
  endtask

  task automatic model_reset();
    m_main_due = 0;
    m_rr       = 0;
    m_pend     = 0;
  endtask

  // One full phase, starting with the DUT in ARB. nl/nh are applied during RUN.
  task automatic do_phase(input int hold, input int run, input bit ped_run,
                          input bit ped_on_hs, input logic [2:0] nl, input logic [2:0] nh);
    int eid, elen, elen6;
    chk("arb_busy", busy, 0);
    chk("arb_valid", phase_valid, 0);
    predict(eid, elen, elen6);
    tick();
    chk("offer_valid", phase_valid, 1);
    chk("offer_id", phase_id, eid);
    chk("offer_len", green_len, elen);
    chk("offer_len_pc6", green_len2, elen6);
    chk("offer_busy", busy, 1);
    for (int i = 0; i < hold; i++) begin
      phase_ready = 1'b0;
      phase_done  = 1'($urandom_range(0, 1));
      tick();
      chk("hold_valid", phase_valid, 1);
      chk("hold_id", phase_id, eid);
      chk("hold_len", green_len, elen);
    end
    phase_done  = 1'b0;
    phase_ready = 1'b1;
    ped_btn     = ped_on_hs;
    tick();
    ped_btn = 1'b0;
    if (eid == 3) m_pend = ped_on_hs;
    else          m_pend = m_pend | ped_on_hs;
    chk("run_valid", phase_valid, 0);
    chk("run_busy", busy, 1);
    chk("hs_ped_pending", ped_pending, m_pend);
    L = nl;
    H = nh;
    for (int i = 0; i < run; i++) begin
      if (ped_run && i == 0) begin
        ped_btn = 1'b1;
        m_pend  = 1;
      end
      tick();
      ped_btn = 1'b0;
      chk("run_valid", phase_valid, 0);
      chk("run_busy", busy, 1);
    end
    chk("run_ped_pending", ped_pending, m_pend);
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    for (int c = 0; c < ALLRED; c++) begin
      chk("clear_busy", busy, 1);
      chk("clear_valid", phase_valid, 0);
      tick();
    end
  endtask

  initial begin
    int eid, elen, elen6;
    reset = 1'b1; L = 3'b000; H = 3'b000;
    ped_btn = 1'b0; phase_ready = 1'b0; phase_done = 1'b0;
    model_reset();
    tick(); tick();
    chk("rst_valid", phase_valid, 0);
    chk("rst_id", phase_id, 0);
    chk("rst_len", green_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ped", ped_pending, 0);
    reset = 1'b0;
    phase_ready = 1'b1;

    // Idle: main only.
    do_phase(0, 2, 0, 0, 3'b000, 3'b000);
    do_phase(1, 1, 0, 0, 3'b000, 3'b000);
    do_phase(0, 3, 0, 0, 3'b110, 3'b000);
    // Side queue of two: alternates main and side; one long backpressure hold.
    do_phase(10, 2, 0, 0, 3'b110, 3'b000);
    do_phase(0, 1, 0, 0, 3'b110, 3'b000);
    do_phase(2, 1, 0, 0, 3'b110, 3'b000);
    do_phase(0, 1, 0, 0, 3'b111, 3'b111);
    // Both queues full: round-robin between side and left, main in between.
    for (int i = 0; i < 6; i++) do_phase(0, 1, 0, 0, 3'b111, 3'b111);
    // Non-thermometer code counts by popcount.
    do_phase(0, 1, 0, 0, 3'b010, 3'b101);
    do_phase(0, 1, 0, 0, 3'b000, 3'b000);
    // Pedestrian press during RUN, then presses on handshake cycles.
    do_phase(0, 2, 1, 0, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) do_phase(0, 1, 0, 1, 3'b000, 3'b000);
    do_phase(0, 1, 0, 0, 3'b000, 3'b000);
    do_phase(0, 1, 0, 0, 3'b000, 3'b000);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      do_phase($urandom_range(0, 3), $urandom_range(1, 4),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Reset in RUN together with phase_done.
    L = 3'b000; H = 3'b000;
    predict(eid, elen, elen6);
    tick();
    phase_ready = 1'b1;
    tick();
    chk("pre_rst_busy", busy, 1);
    reset      = 1'b1;
    phase_done = 1'b1;
    tick();
    chk("midrst_valid", phase_valid, 0);
    chk("midrst_id", phase_id, 0);
    chk("midrst_len", green_len, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ped", ped_pending, 0);
    reset      = 1'b0;
    phase_done = 1'b0;
    model_reset();
    do_phase(0, 1, 0, 0, 3'b000, 3'b000);
    do_phase(0, 1, 0, 0, 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
